sequenciador_notas: RTL
=======================

# sequenciador_notas

Melody sequencer that sits directly upstream of the 7-segment note display (ModuloDisp). It steps through a fixed song table, holding each note for a programmable number of beats. Its registered `TOM`/`NOTAS` outputs drive the display's `TOM_module`/`NOTAS` inputs unchanged. Control is start/stop/loop with a one-cycle `done` pulse at the end of a non-looped song.

## Interface
- `TICKS_PER_BEAT`, default 4: clock cycles per beat, ≥1.
- `SONG_LEN`, default 16: number of song table entries used, 1..16.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level sampled each cycle; starts playback from entry 0 when idle.
- `stop`  in  1  aborts playback; returns to idle next cycle.
- `loop`  in  1  sampled at the end of the last note; 1 restarts at entry 0.
- `TOM`  out  1  tone bit of the current note, to the display.
- `NOTAS`  out  3  note code of the current note, to the display.
- `playing`  out  1  high while a note is being output.
- `idx`  out  4  current song entry index.
- `done`  out  1  one-cycle pulse after the last note when not looping.

## Operation
- Song entry format, 6 bits: `{tom, nota[2:0], dur[1:0]}`. Note length is (dur+1) beats, i.e. (dur+1)·TICKS_PER_BEAT cycles.
- Default song: entry i has tom=i[3], nota=i[2:0], dur=i[1:0]. This is the same sweep the display bench uses.
- States:
  - IDLE: outputs TOM=0, NOTAS=000, playing=0, idx=0. `start`=1 → PLAY.
  - PLAY: outputs entry[idx]. When the note length expires:
    - idx<SONG_LEN-1: idx+1, stay in PLAY.
    - idx=SONG_LEN-1 and loop=1: idx=0, stay in PLAY.
    - idx=SONG_LEN-1 and loop=0: → DONE.
  - DONE: one cycle with done=1, outputs as in IDLE, then → IDLE.
- `stop`=1 in any state → IDLE next cycle. `stop` beats `start` in the same cycle. `stop` during DONE still produces the done pulse that cycle; the next state is IDLE.
- `start` while in PLAY or DONE is ignored (no restart).
- Duration counting:
  - Beat prescaler counts 0..TICKS_PER_BEAT-1 and emits a one-cycle `beat` at terminal count.
  - Beat counter counts 0..dur. The note ends on the `beat` cycle where the beat counter equals dur.
  - Both counters clear on every note change and on entry to PLAY.
- Width rules: the prescaler is $clog2(TICKS_PER_BEAT) bits (min 1), the beat counter is 2 bits, and idx is 4 bits. idx wraps only via the loop path, never by overflow.

## Timing
- All outputs are registered.
- Reset value: state=IDLE, TOM=0, NOTAS=000, playing=0, idx=0, done=0, counters=0.
- Reset mid-playback takes effect immediately (asynchronous) and playback does not resume on release.
- Latency: `start` high at edge N → TOM/NOTAS = entry 0 and playing=1 after edge N+1.
- Note k is held exactly (dur_k+1)·TICKS_PER_BEAT cycles. The next entry appears on the cycle after the last one, with no gap cycles.
- Done pulse: the cycle after the last note's final cycle. `start` sampled high during DONE is ignored; `start` in the following IDLE cycle restarts playback.
- `stop` high at edge N → IDLE outputs after edge N+1.

## Structure
- Package `nota_pkg`:
  - entry field widths and the localparam song table as a 16×6 constant array;
  - the state encoding enum {IDLE, PLAY, DONE};
  - a helper function returning the note length in cycles, for the bench.
- Sub-module `beat_prescaler`:
  - parameter TICKS_PER_BEAT;
  - inputs clk, rst, clear; output beat.
  - The FSM, beat counter and table lookup stay in `sequenciador_notas`.
- Top-level wiring: instantiate next to ModuloDisp with `.TOM_module(TOM)` and `.NOTAS(NOTAS)`.

## Test plan
- Reset, then start=0 for 10 cycles → TOM=0, NOTAS=000, playing=0, idx=0 and done=0 throughout.
- Default parameters, one-cycle start pulse, loop=0:
  - NOTAS=000 for 4 cycles, then 001 for 8, then 010 for 12, then 011 for 16, then 100 for 4.
  - TOM=0 for entries 0–7 and TOM=1 for entries 8–15.
  - done pulses exactly 160 cycles after playing rises.
- loop=1 held through the end of entry 15 → idx returns to 0 with TOM=0, NOTAS=000 on the next cycle, no done pulse and no gap.
- stop asserted in the 3rd cycle of entry 2 → IDLE outputs on the next cycle and no done. A later start replays from entry 0 with full durations.
- start and stop high in the same cycle from IDLE → remains IDLE. start asserted during PLAY → idx sequence unaffected.
- rst pulsed for 1 cycle during entry 5 with TICKS_PER_BEAT=1 and SONG_LEN=8 → all outputs at reset values immediately. After release, a song run without reset takes 20 cycles, then done.

Source files
------------

// File: rtl/nota_pkg.sv
// Shared definitions for the melody sequencer: entry layout, the fixed song
// table, the controller state encoding and a note-length helper.
package nota_pkg;

  localparam int TOM_W   = 1;
  localparam int NOTA_W  = 3;
  localparam int DUR_W   = 2;
  localparam int ENTRY_W = TOM_W + NOTA_W + DUR_W;
  localparam int TABLE_DEPTH = 16;

  typedef logic [ENTRY_W-1:0] entry_t;

  // Entry i = {i[3], i[2:0], i[1:0]}: the same sweep the display bench uses.
  localparam entry_t SONG_TABLE [TABLE_DEPTH] = '{
    6'b000000, 6'b000101, 6'b001010, 6'b001111,
    6'b010000, 6'b010101, 6'b011010, 6'b011111,
    6'b100000, 6'b100101, 6'b101010, 6'b101111,
    6'b110000, 6'b110101, 6'b111010, 6'b111111
  };

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } state_t;

  function automatic int note_cycles(input logic [DUR_W-1:0] dur, input int ticks_per_beat);
    return (int'(dur) + 1) * ticks_per_beat;
  endfunction

endpackage

// File: rtl/beat_prescaler.sv
// Divides the clock into beats: a one-cycle beat at the terminal count of a
// 0..TICKS_PER_BEAT-1 counter, restartable by a synchronous clear.
module beat_prescaler #(
  parameter int TICKS_PER_BEAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic beat
);

  localparam int CNT_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICKS_PER_BEAT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear || beat) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign beat = (cnt_reg == TERM);

endmodule

// File: rtl/sequenciador_notas.sv
// Melody sequencer feeding the 7-segment note display: steps through the song
// table holding each note (dur+1) beats, with start/stop/loop and a done pulse.
module sequenciador_notas
  import nota_pkg::*;
#(
  parameter int TICKS_PER_BEAT = 4,
  parameter int SONG_LEN       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic              TOM,
  output logic [NOTA_W-1:0] NOTAS,
  output logic              playing,
  output logic [3:0]        idx,
  output logic              done
);

  localparam logic [3:0] LAST_IDX = 4'(SONG_LEN - 1);

  state_t            state_reg, state_next;
  logic [3:0]        idx_reg, idx_next;
  logic [DUR_W-1:0]  beat_cnt_reg;
  logic [DUR_W-1:0]  dur;
  logic              beat;
  logic              note_end;
  logic              clear;
  logic              tom_reg;
  logic [NOTA_W-1:0] nota_reg;
  logic              playing_reg;
  logic              done_reg;

  assign dur      = SONG_TABLE[idx_reg][DUR_W-1:0];
  assign note_end = (state_reg == PLAY) && beat && (beat_cnt_reg == dur);
  // Counters restart whenever we are not mid-note, so every note starts at zero.
  assign clear    = (state_reg != PLAY) || note_end;

  beat_prescaler #(
    .TICKS_PER_BEAT(TICKS_PER_BEAT)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .beat (beat)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        idx_next = 4'd0;
        if (start && !stop) begin
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (stop) begin
          state_next = IDLE;
          idx_next   = 4'd0;
        end else if (note_end) begin
          if (idx_reg != LAST_IDX) begin
            idx_next = idx_reg + 4'd1;
          end else if (loop) begin
            idx_next = 4'd0;
          end else begin
            state_next = DONE;
            idx_next   = 4'd0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 4'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= 4'd0;
      beat_cnt_reg <= '0;
      tom_reg      <= 1'b0;
      nota_reg     <= '0;
      playing_reg  <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (clear) begin
        beat_cnt_reg <= '0;
      end else if (beat) begin
        beat_cnt_reg <= beat_cnt_reg + DUR_W'(1);
      end
      playing_reg <= (state_next == PLAY);
      done_reg    <= (state_next == DONE);
      if (state_next == PLAY) begin
        tom_reg  <= SONG_TABLE[idx_next][ENTRY_W-1];
        nota_reg <= SONG_TABLE[idx_next][ENTRY_W-2 -: NOTA_W];
      end else begin
        tom_reg  <= 1'b0;
        nota_reg <= '0;
      end
    end
  end

  assign TOM     = tom_reg;
  assign NOTAS   = nota_reg;
  assign playing = playing_reg;
  assign idx     = idx_reg;
  assign done    = done_reg;

endmodule
